// File: rtl/div_unit_if.sv
// div_unit_if: operand/result bundle between the execute stage and the divider.
//   master (execute stage): drives signed_div_i, opdata1_i, opdata2_i, start_i,
//                           annul_i; observes result_o, ready_o.
//   slave  (div_unit):      the reverse.
//   result_o is {remainder, quotient}, i.e. {HI, LO}.
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                signed_div_i;
    logic [DATA_W-1:0]   opdata1_i;
    logic [DATA_W-1:0]   opdata2_i;
    logic                start_i;
    logic                annul_i;
    logic [2*DATA_W-1:0] result_o;
    logic                ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for div/divu, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : div_unit_if.slave (operands, signedness, start/annul in; result/ready out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// FREE    | idle, waiting for start_i (annul_i blocks acceptance)
// BY_ZERO | divisor was zero; result 0 is published on the next edge
// ON      | iterating: DATA_W shift-subtract steps, then publish result
// END     | result_o/ready_o held until start_i drops
module div_unit #(
    parameter int DATA_W = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;   // dividend magnitude, consumed MSB first
    logic [DATA_W-1:0]   dvs_q, dvs_d;   // divisor magnitude
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     partial;
    logic                neg1, neg2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            quot_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            quot_q     <= quot_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        neg1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        neg2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];

        // rem < divisor always, so the shifted value is below 2*divisor and the
        // 33-bit difference's MSB is a valid sign.
        shifted = {rem_q, dvd_q[DATA_W-1]};
        partial = shifted - {1'b0, dvs_q};

        unique case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    dvd_d      = neg1 ? -bus.opdata1_i : bus.opdata1_i;
                    dvs_d      = neg2 ? -bus.opdata2_i : bus.opdata2_i;
                    neg_quot_d = neg1 ^ neg2;
                    neg_rem_d  = neg1;
                    rem_d      = '0;
                    quot_d     = '0;
                    cnt_d      = '0;
                    state_d    = (bus.opdata2_i == '0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d = FREE;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = {neg_rem_q  ? -rem_q  : rem_q,
                                neg_quot_q ? -quot_q : quot_q};
                end else begin
                    if (!partial[DATA_W]) begin
                        rem_d  = partial[DATA_W-1:0];
                        quot_d = {quot_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d  = shifted[DATA_W-1:0];
                        quot_d = {quot_q[DATA_W-2:0], 1'b0};
                    end
                    dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: divide magnitudes with wide arithmetic, then apply the sign rules
    // (quotient negative when signs differ, remainder takes the dividend's sign).
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ma, mb, q, r;
        bit     na, nb;
        if (b == 32'd0) return 64'd0;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'sd4294967296 - longint'({32'd0, a})) : longint'({32'd0, a});
        mb = nb ? (64'sd4294967296 - longint'({32'd0, b})) : longint'({32'd0, b});
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one division with start held until ready, checks latency, result,
    // hold behaviour and release. change_at > 0 scrambles the operand inputs
    // that many cycles after acceptance.
    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int change_at);
        int cycles;
        int exp_lat;
        exp_lat = (b == 32'd0) ? 2 : 34;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (change_at > 0 && cycles == change_at) begin
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
                bus.signed_div_i = ~sgn;
            end
            if (bus.ready_o) break;
        end
        check({tag, " latency"}, 64'(cycles), 64'(exp_lat));
        check({tag, " result"}, bus.result_o, exp);
        @(negedge clk);
        check({tag, " hold"}, {bus.result_o[62:0], bus.ready_o}, {exp[62:0], 1'b1});
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, " release"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
    endtask

    initial begin
        int seen;
        n_cmp = 0;
        n_err = 0;
        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        #12;
        check("reset outputs", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle after reset", {bus.result_o[62:0], bus.ready_o}, 64'd0);

        run_div("u100/7",   1'b0, 32'd100,        32'd7,        {32'h2, 32'hE}, 0);
        run_div("s-7/2",    1'b1, 32'hFFFF_FFF9,  32'h2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_div("s7/-2",    1'b1, 32'h7,          32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 0);
        run_div("u5/0",     1'b0, 32'd5,          32'd0,        64'd0, 0);
        run_div("s5/0",     1'b1, 32'd5,          32'd0,        64'd0, 0);
        run_div("s ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0);
        run_div("uFFFF/1",  1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0, 32'hFFFF_FFFF}, 0);

        // Annul ten cycles into ON: no result ever appears.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.ready_o) seen++;
        end
        check("annul no ready", 64'(seen), 64'd0);
        run_div("after annul 9/3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 0);

        // Operand inputs scrambled mid-division.
        run_div("opchange", 1'b1, 32'hFFFF_FC18, 32'd7, model(1'b1, 32'hFFFF_FC18, 32'd7), 5);

        // Reset pulsed 20 cycles into a division, then the same division again.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd12345;
        bus.opdata2_i    = 32'd17;
        bus.start_i      = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid reset outputs", {bus.result_o[62:0], bus.ready_o}, 64'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("after reset", 1'b0, 32'd12345, 32'd17, {32'd3, 32'd726}, 0);

        // Randomised operands against the reference.
        for (int i = 0; i < 30; i++) begin
            bit          sgn;
            logic [31:0] a;
            logic [31:0] b;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_div("random", sgn, a, b, model(sgn, a, b), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
